// File: rtl/hmmm_core.sv
// rtl/hmmm_core.sv - parametrised multicycle HMMM-style core with req/ready memory port
module hmmm_core #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NREGS   = 8,
    parameter int INSTR_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    localparam int RW    = $clog2(NREGS);
    localparam int IMM_W = INSTR_W - 4 - RW;

    localparam logic [3:0] OP_HALT   = 4'h0;
    localparam logic [3:0] OP_SETN   = 4'h1;
    localparam logic [3:0] OP_LOADR  = 4'h2;
    localparam logic [3:0] OP_STORER = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_SUB    = 4'h5;
    localparam logic [3:0] OP_JUMPN  = 4'h8;
    localparam logic [3:0] OP_JUMPR  = 4'h9;
    localparam logic [3:0] OP_JEQZN  = 4'hA;
    localparam logic [3:0] OP_JNEZN  = 4'hB;
    localparam logic [3:0] OP_JGTZN  = 4'hC;
    localparam logic [3:0] OP_JLTZN  = 4'hD;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NREGS];

    logic [3:0]          funct;
    logic [RW-1:0]       rd;
    logic [RW-1:0]       ra1;
    logic [RW-1:0]       ra2;
    logic [IMM_W-1:0]    imm_raw;
    logic [DATA_W-1:0]   imm_ext;
    logic [ADDR_W-1:0]   target;

    logic [RW-1:0]       porta_sel;
    logic [DATA_W-1:0]   porta;
    logic [DATA_W-1:0]   portb;
    logic [ADDR_W-1:0]   adr_a;
    logic [ADDR_W-1:0]   adr_b;

    logic                is_zero;
    logic                is_neg;
    logic                taken;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   pc_inc;

    assign funct   = ir[3:0];
    assign rd      = ir[RW+3:4];
    assign ra1     = ir[2*RW+3:RW+4];
    assign ra2     = ir[3*RW+3:2*RW+4];
    assign imm_raw = ir[INSTR_W-1:RW+4];
    assign target  = imm_raw[ADDR_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);

    generate
        if (IMM_W >= DATA_W) begin : g_imm_trunc
            assign imm_ext = imm_raw[DATA_W-1:0];
        end else begin : g_imm_sext
            assign imm_ext = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
        end

        if (DATA_W >= ADDR_W) begin : g_adr_trunc
            assign adr_a = porta[ADDR_W-1:0];
            assign adr_b = portb[ADDR_W-1:0];
        end else begin : g_adr_zext
            assign adr_a = {{(ADDR_W-DATA_W){1'b0}}, porta};
            assign adr_b = {{(ADDR_W-DATA_W){1'b0}}, portb};
        end
    endgenerate

    // Port A serves ra1 for ALU/jumpr and rd for stores and branch tests; port B is always ra2.
    always_comb begin
        porta_sel = rd;
        if (funct == OP_ADD || funct == OP_SUB || funct == OP_JUMPR) begin
            porta_sel = ra1;
        end
    end

    assign porta = regs[porta_sel];
    assign portb = regs[ra2];

    assign is_zero = (porta == '0);
    assign is_neg  = porta[DATA_W-1];

    always_comb begin
        taken = 1'b0;
        case (funct)
            OP_JEQZN: taken = is_zero;
            OP_JNEZN: taken = ~is_zero;
            OP_JGTZN: taken = ~is_neg & ~is_zero;
            OP_JLTZN: taken = is_neg;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (state == S_EXEC) begin
            case (funct)
                OP_SETN: begin
                    wr_en   = 1'b1;
                    wr_data = imm_ext;
                end
                OP_ADD: begin
                    wr_en   = 1'b1;
                    wr_data = porta + portb;
                end
                OP_SUB: begin
                    wr_en   = 1'b1;
                    wr_data = porta - portb;
                end
                default: begin
                    wr_en   = 1'b0;
                    wr_data = '0;
                end
            endcase
        end else if (state == S_MEM && mem_ready && funct == OP_LOADR) begin
            wr_en   = 1'b1;
            wr_data = mem_rdata[DATA_W-1:0];
        end
    end

    // r0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && rd != '0) begin
            regs[rd] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            pc_q   <= '0;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (funct)
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        OP_LOADR, OP_STORER: state <= S_MEM;
                        OP_JUMPN: pc_q <= target;
                        OP_JUMPR: pc_q <= adr_a;
                        OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN:
                            pc_q <= taken ? target : pc_inc;
                        default: pc_q <= pc_inc;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        pc_q  <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Request is gated by reset so an in-flight access is dropped the moment reset rises.
    assign mem_req   = ~reset & (state == S_FETCH || state == S_MEM);
    assign mem_we    = ~reset & (state == S_MEM) & (funct == OP_STORER);
    assign mem_adr   = (state == S_MEM) ? adr_b : pc_q;
    assign mem_wdata = porta;
    assign pc        = pc_q;

endmodule

// File: tb/tb_hmmm_core.sv
// tb/tb_hmmm_core.sv - directed scoreboard bench for hmmm_core
module tb_hmmm_core;

    typedef struct {
        logic [7:0]  adr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [7:0]  mem_adr, mem_wdata;
    logic [14:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic [7:0]  pc;
    logic        halted;

    logic        reset2;
    logic        d2_req, d2_we;
    logic [7:0]  d2_adr;
    logic [15:0] d2_wdata;
    logic [23:0] d2_rdata;
    logic [7:0]  d2_pc;
    logic        d2_halted;

    logic [14:0] prog [256];
    logic [23:0] prog2 [256];
    logic [7:0]  dmem [256];
    logic [255:0] dvalid;
    int          stall_n;
    int          cnt;
    logic        done_last;
    logic        prev_stall;
    logic [7:0]  prev_adr, prev_wdata;
    logic        prev_we;

    wr_t         exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    hmmm_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .halted(halted)
    );

    hmmm_core #(.DATA_W(16), .ADDR_W(8), .NREGS(16), .INSTR_W(24)) dut2 (
        .clk(clk), .reset(reset2), .mem_req(d2_req), .mem_we(d2_we),
        .mem_adr(d2_adr), .mem_wdata(d2_wdata), .mem_rdata(d2_rdata),
        .mem_ready(1'b1), .pc(d2_pc), .halted(d2_halted)
    );

    assign mem_rdata = dvalid[mem_adr] ? {7'h00, dmem[mem_adr]} : prog[mem_adr];
    assign d2_rdata  = prog2[d2_adr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input logic [7:0] adr, input logic [15:0] data);
        wr_t e;
        if (exp_q.size() == 0) begin
            check("write_expected", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check("write_adr", 32'(adr), 32'(e.adr));
            check("write_data", 32'(data), 32'(e.data));
        end
    endtask

    function automatic logic [14:0] ei(input logic [3:0] f, input logic [2:0] rd, input logic [7:0] imm);
        return {imm, rd, f};
    endfunction

    function automatic logic [14:0] er(input logic [3:0] f, input logic [2:0] rd,
                                       input logic [2:0] ra1, input logic [2:0] ra2);
        return {2'b00, ra2, ra1, rd, f};
    endfunction

    // Memory ready model: each new access waits stall_n cycles before ready.
    always @(posedge clk) begin
        #1;
        if (reset || !mem_req || done_last) cnt = stall_n;
        else if (cnt > 0) cnt = cnt - 1;
        mem_ready = (cnt == 0);
    end

    always @(negedge clk) begin
        if (reset) begin
            dvalid     <= '0;
            prev_stall <= 1'b0;
            done_last  <= 1'b0;
        end else begin
            if (mem_req && mem_ready && mem_we) begin
                chk_write(mem_adr, {8'h00, mem_wdata});
                dmem[mem_adr]   <= mem_wdata;
                dvalid[mem_adr] <= 1'b1;
            end
            if (prev_stall && mem_req) begin
                check("hold_adr", 32'(mem_adr), 32'(prev_adr));
                check("hold_we", 32'(mem_we), 32'(prev_we));
                if (prev_we) check("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
            end
            prev_stall <= mem_req && !mem_ready;
            prev_adr   <= mem_adr;
            prev_we    <= mem_we;
            prev_wdata <= mem_wdata;
            done_last  <= mem_req && mem_ready;
        end
    end

    always @(negedge clk) begin
        if (!reset2 && d2_req && d2_we) chk_write(d2_adr, d2_wdata);
    end

    task automatic start(input int s);
        @(negedge clk);
        reset   = 1'b1;
        stall_n = s;
        for (int i = 0; i < 256; i++) prog[i] = 15'h0000;
        exp_q.delete();
    endtask

    task automatic go();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(halted), 1);
    endtask

    initial begin
        reset   = 1'b1;
        reset2  = 1'b1;
        stall_n = 0;
        for (int i = 0; i < 256; i++) prog2[i] = 24'h000000;

        // setn/setn/add/halt timing, reset values
        start(0);
        prog[0] = ei(4'h1, 3'd1, 8'd5);
        prog[1] = ei(4'h1, 3'd2, 8'hFD);
        prog[2] = er(4'h4, 3'd3, 3'd1, 3'd2);
        prog[3] = ei(4'h0, 3'd0, 8'h00);
        #1;
        check("reset_mem_req", 32'(mem_req), 0);
        check("reset_pc", 32'(pc), 0);
        check("reset_halted", 32'(halted), 0);
        go();
        #1;
        check("release_mem_req", 32'(mem_req), 1);
        check("release_mem_adr", 32'(mem_adr), 0);
        repeat (7) begin @(posedge clk); #1; end
        check("halt_not_yet", 32'(halted), 0);
        @(posedge clk); #1;
        check("halt_at_8", 32'(halted), 1);
        check("halt_pc", 32'(pc), 3);
        check("halt_no_req", 32'(mem_req), 0);

        // add result observed through a store
        start(0);
        prog[0] = ei(4'h1, 3'd1, 8'd5);
        prog[1] = ei(4'h1, 3'd2, 8'hFD);
        prog[2] = er(4'h4, 3'd3, 3'd1, 3'd2);
        prog[3] = ei(4'h1, 3'd4, 8'h80);
        prog[4] = er(4'h3, 3'd3, 3'd0, 3'd4);
        exp_q.push_back('{adr: 8'h80, data: 16'h0002});
        go();
        wait_halt("add_halt", 100);
        check("add_pc", 32'(pc), 5);
        check("add_drain", 32'(exp_q.size()), 0);

        // sub wrap, jltzn taken, jgtzn not taken
        start(0);
        prog[0]     = ei(4'h1, 3'd1, 8'h00);
        prog[1]     = ei(4'h1, 3'd2, 8'h01);
        prog[2]     = er(4'h5, 3'd3, 3'd1, 3'd2);
        prog[3]     = ei(4'h1, 3'd4, 8'h80);
        prog[4]     = er(4'h3, 3'd3, 3'd0, 3'd4);
        prog[5]     = ei(4'hD, 3'd3, 8'h20);
        prog[8'h20] = ei(4'hC, 3'd3, 8'h30);
        exp_q.push_back('{adr: 8'h80, data: 16'h00FF});
        go();
        wait_halt("sub_halt", 100);
        check("branch_pc", 32'(pc), 32'h21);
        check("sub_drain", 32'(exp_q.size()), 0);

        // store then load with 3 wait cycles per access
        start(3);
        prog[0]     = ei(4'h1, 3'd1, 8'h5A);
        prog[1]     = ei(4'h1, 3'd2, 8'h40);
        prog[2]     = er(4'h3, 3'd1, 3'd0, 3'd2);
        prog[3]     = er(4'h2, 3'd4, 3'd0, 3'd2);
        prog[4]     = ei(4'h1, 3'd5, 8'h41);
        prog[5]     = er(4'h3, 3'd4, 3'd0, 3'd5);
        prog[8'h40] = 15'h7F00;
        exp_q.push_back('{adr: 8'h40, data: 16'h005A});
        exp_q.push_back('{adr: 8'h41, data: 16'h005A});
        go();
        wait_halt("stall_halt", 300);
        check("stall_pc", 32'(pc), 6);
        check("stall_drain", 32'(exp_q.size()), 0);

        // r0 hardwired zero, jumpr r0
        start(0);
        prog[0] = ei(4'h1, 3'd0, 8'd7);
        prog[1] = er(4'h4, 3'd1, 3'd0, 3'd0);
        prog[2] = ei(4'h1, 3'd2, 8'h80);
        prog[3] = er(4'h3, 3'd1, 3'd0, 3'd2);
        prog[4] = ei(4'h1, 3'd3, 8'h81);
        prog[5] = er(4'h3, 3'd0, 3'd0, 3'd3);
        prog[6] = er(4'h9, 3'd0, 3'd0, 3'd0);
        exp_q.push_back('{adr: 8'h80, data: 16'h0000});
        exp_q.push_back('{adr: 8'h81, data: 16'h0000});
        go();
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
            check("r0_drain", 32'(exp_q.size()), 0);
            n = 0;
            while (!(mem_req && !mem_we && mem_adr == 8'h00) && n < 20) begin
                @(posedge clk); #1; n++;
            end
            check("jumpr_fetch0", 32'(mem_req && mem_adr == 8'h00), 1);
            check("jumpr_pc", 32'(pc), 0);
        end

        // reset during a stalled store aborts it
        start(5);
        prog[0] = ei(4'h1, 3'd1, 8'h33);
        prog[1] = ei(4'h1, 3'd2, 8'h50);
        prog[2] = er(4'h3, 3'd1, 3'd0, 3'd2);
        go();
        begin
            int n = 0;
            while (!(mem_req && mem_we) && n < 100) begin @(posedge clk); #1; n++; end
            check("store_pending", 32'(mem_req && mem_we), 1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_mem_req", 32'(mem_req), 0);
        check("abort_pc", 32'(pc), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_fetch_req", 32'(mem_req), 1);
        check("abort_fetch_adr", 32'(mem_adr), 0);
        check("abort_fetch_we", 32'(mem_we), 0);

        // jump to top of memory, NOP wraps PC to 0, jnezn both ways
        start(0);
        prog[0]     = ei(4'hB, 3'd6, 8'h10);
        prog[1]     = ei(4'h1, 3'd6, 8'h01);
        prog[2]     = ei(4'h8, 3'd0, 8'hFF);
        prog[8'hFF] = ei(4'h6, 3'd0, 8'h00);
        prog[8'h10] = ei(4'h1, 3'd7, 8'h90);
        prog[8'h11] = er(4'h3, 3'd6, 3'd0, 3'd7);
        exp_q.push_back('{adr: 8'h90, data: 16'h0001});
        go();
        wait_halt("wrap_halt", 100);
        check("wrap_pc", 32'(pc), 32'h12);
        check("wrap_drain", 32'(exp_q.size()), 0);

        // wide build: 16-bit data, 16 registers
        @(negedge clk);
        reset = 1'b1;
        prog2[0]     = {16'hFFFF, 4'd15, 4'h1};
        prog2[1]     = {16'h0080, 4'd14, 4'h1};
        prog2[2]     = {8'h00, 4'd14, 4'd0, 4'd15, 4'h3};
        prog2[3]     = {16'h0012, 4'd15, 4'hB};
        exp_q.push_back('{adr: 8'h80, data: 16'hFFFF});
        @(negedge clk);
        reset2 = 1'b0;
        begin
            int n = 0;
            while (!d2_halted && n < 100) begin @(posedge clk); #1; n++; end
            check("wide_halt", 32'(d2_halted), 1);
            check("wide_pc", 32'(d2_pc), 32'h12);
            check("wide_drain", 32'(exp_q.size()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hmmm_core.md
# hmmm_core

Parametrised multicycle HMMM-style processor core: the successor of the fixed 8-bit, two-phase processor. Data width, address width, register count and instruction width are parameters. Memory is reached over a single req/ready handshake, so the core stalls correctly on variable-latency memory. The core adds a hardwired-zero r0, a halt instruction and a debug view of PC and halt status, and sits between the system clock/reset and a unified instruction/data memory.

## Interface
- DATA_W, 8, register/ALU data width
- ADDR_W, 8, memory address and PC width
- NREGS, 8, number of registers, power of two; RW = log2(NREGS)
- INSTR_W, 15, instruction width; must be ≥ 4+3·RW; IMM_W = INSTR_W−4−RW; must have IMM_W ≥ ADDR_W
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mem_req  out  1  memory request (fetch or data access)
- mem_we  out  1  1 = write, valid while mem_req
- mem_adr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  INSTR_W  read data, sampled when mem_req & mem_ready; loads use bits [DATA_W-1:0]
- mem_ready  in  1  access completes this cycle
- pc  out  ADDR_W  current PC
- halted  out  1  core is in HALT

## Operation
- Fields: funct = ir[3:0]; rd = ir[RW+3:4]; ra1 = ir[2RW+3:RW+4]; ra2 = ir[3RW+3:2RW+4]; imm = ir[INSTR_W-1:RW+4], sign-extended to DATA_W. ra1/ra2 overlap imm by design.
- Opcodes:
  - 0x0 halt
  - 0x1 setn: R[rd]=imm
  - 0x2 loadr: R[rd]=M[R[ra2]]
  - 0x3 storer: M[R[ra2]]=R[rd]
  - 0x4 add: R[rd]=R[ra1]+R[ra2]
  - 0x5 sub: R[rd]=R[ra1]−R[ra2]
  - 0x8 jumpn: PC=imm[ADDR_W-1:0]
  - 0x9 jumpr: PC=R[ra1]
  - 0xA jeqzn / 0xB jnezn / 0xC jgtzn / 0xD jltzn: test R[rd]; if taken, PC=imm[ADDR_W-1:0]
  - all other codes: NOP
- Conditions: zero = R[rd]==0; negative = R[rd][DATA_W-1]; gtz = ~negative & ~zero.
- Arithmetic wraps mod 2^DATA_W; no flags retained. Register-to-address uses the low ADDR_W bits, zero-extended if DATA_W < ADDR_W. PC+1 wraps mod 2^ADDR_W.
- r0 reads as 0 always; writes to r0 are dropped. Two read ports, one write port.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, mem_adr=PC. On mem_ready, IR ← mem_rdata, go to EXEC.
  - EXEC: decode IR.
    - setn/add/sub/NOP: write rd if applicable, PC ← PC+1, go to FETCH.
    - Jumps/branches: PC ← target if taken, else PC+1; go to FETCH.
    - loadr/storer: go to MEM; PC unchanged.
    - halt: go to HALT; PC unchanged.
  - MEM: mem_req=1, mem_adr=R[ra2], mem_we=(storer), mem_wdata=R[rd]. On mem_ready: a load writes R[rd] ← mem_rdata[DATA_W-1:0]; PC ← PC+1; go to FETCH.
  - HALT: terminal until reset; mem_req=0; halted=1.
- Handshake: while mem_req=1 and mem_ready=0, mem_adr, mem_we and mem_wdata are held stable and no architectural state changes. mem_ready while mem_req=0 is ignored.

## Timing
- Reset values (asynchronous): state=FETCH, PC=0, IR=0, all registers 0, halted=0. mem_req is forced to 0 while reset is high and asserts on the first cycle after release with mem_adr=0.
- With zero-wait memory (ready tied high): ALU/branch/setn/halt take 2 cycles; loadr/storer take 3 cycles. Each wait cycle adds 1.
- Register writes land on the EXEC or MEM completion edge and are visible to the next instruction's EXEC.
- A store is a single req&ready cycle with mem_we=1; the core never issues a duplicate write.
- Reset asserted mid-access (FETCH or MEM) aborts the access immediately. Any store not yet acknowledged is not completed.
- A branch to its own address loops indefinitely (no special case). A jump to 2^ADDR_W−1 followed by a NOP wraps PC to 0.

## Test plan
- Reset release, ready=1, program "setn r1,5; setn r2,−3; add r3,r1,r2; halt" → r3=2, halted=1 after 8 cycles, pc=3 at halt.
- sub with wrap: r1=0, r2=1, sub r3,r1,r2 → r3=0xFF; then jltzn r3,0x20 → pc=0x20; jgtzn on r3 not taken → pc+1.
- Store/load under stalls: ready low for 3 cycles on each access; storer r1(=0x5A)→[r2=0x40], loadr r4←[0x40] → adr/we/wdata stable through stalls, exactly one write, r4=0x5A.
- r0 write: setn r0,7; add r1,r0,r0 → r1=0; jumpr r0 → pc=0.
- Reset pulse asserted in MEM of a storer with ready=0 → no write seen, pc=0, state FETCH, mem_req=0 during reset.
- Parameter build DATA_W=16, NREGS=16, INSTR_W=24: setn r15,−1 → r15=0xFFFF; jnezn r15,0x12 → pc=0x12.
